// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, imem request FSM and instruction buffer FIFO with jump/branch redirect.
// Optional FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [25:0] jump_index,
  input  logic [15:0] branch_imm
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      stateQ, stateD;
  logic [31:0]     pcQ, pcD;
  logic            discardQ, discardD;
  logic [31:0]     discardAddrQ, discardAddrD;
  logic            runQ;
  logic [PtrW-1:0] wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CntW-1:0] countQ, countD;
  logic [31:0]     instrMem [FIFO_DEPTH];
  logic [31:0]     pcMem    [FIFO_DEPTH];

  logic        handshake, redirect, accept, push;
  logic [31:0] pcPlus4, jumpTarget, branchTarget;

  // runQ delays the first request to the cycle after reset release.
  assign imem_req    = runQ & (stateQ == FETCH);
  assign imem_addr   = discardQ ? discardAddrQ : pcQ;
  assign instr_valid = (countQ != '0);
  assign instruction = instr_valid ? instrMem[rdPtrQ] : '0;
  assign instr_pc    = instr_valid ? pcMem[rdPtrQ] : '0;

  always_comb begin
    handshake    = instr_valid & instr_ready;
    redirect     = handshake & (jump | branch_taken);
    accept       = imem_req & imem_ack;
    push         = accept & ~discardQ & ~redirect;
    pcPlus4      = instr_pc + 32'd4;
    jumpTarget   = {pcPlus4[31:28], jump_index, 2'b00};
    branchTarget = pcPlus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  end

  always_comb begin
    pcD          = pcQ;
    discardD     = discardQ;
    discardAddrD = discardAddrQ;
    countD       = countQ;
    wrPtrD       = wrPtrQ;
    rdPtrD       = rdPtrQ;
    if (redirect) begin
      pcD    = jump ? jumpTarget : branchTarget;
      countD = '0;
      wrPtrD = '0;
      rdPtrD = '0;
      // An outstanding request must still complete; its word is thrown away.
      if (imem_req && !imem_ack) begin
        discardD     = 1'b1;
        discardAddrD = imem_addr;
      end
    end else begin
      countD = countQ + CntW'(push) - CntW'(handshake);
      if (push) begin
        pcD    = pcQ + 32'd4;
        wrPtrD = wrPtrQ + PtrW'(1);
      end
      if (handshake) begin
        rdPtrD = rdPtrQ + PtrW'(1);
      end
      if (accept && discardQ) begin
        discardD = 1'b0;
      end
    end
    stateD = (countD == CntW'(FIFO_DEPTH)) ? FULL : FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ       <= FETCH;
      pcQ          <= RESET_PC;
      discardQ     <= 1'b0;
      discardAddrQ <= RESET_PC;
      runQ         <= 1'b0;
      wrPtrQ       <= '0;
      rdPtrQ       <= '0;
      countQ       <= '0;
    end else begin
      stateQ       <= stateD;
      pcQ          <= pcD;
      discardQ     <= discardD;
      discardAddrQ <= discardAddrD;
      runQ         <= 1'b1;
      wrPtrQ       <= wrPtrD;
      rdPtrQ       <= rdPtrD;
      countQ       <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtrQ] <= imem_rdata;
      pcMem[wrPtrQ]    <= pcQ;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetchedQ, flushedQ, flushInc;

  // Flushed entries exclude the redirecting instruction itself, which was consumed.
  always_comb begin
    flushInc = redirect ? (32'(countQ) - 32'd1) : 32'd0;
    if (accept && (redirect || discardQ)) begin
      flushInc = flushInc + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchedQ <= '0;
      flushedQ <= '0;
    end else begin
      fetchedQ <= fetchedQ + 32'(push);
      flushedQ <= flushedQ + flushInc;
    end
  end

  assign perf_fetched = fetchedQ;
  assign perf_flushed = flushedQ;
`endif

endmodule
